// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV immediate decoder feeding a DEPTH-entry output FIFO.
// Define IMM_GEN_ILL_CNT_EN to add a saturating ill_cnt of accepted illegal words.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
`ifdef IMM_GEN_ILL_CNT_EN
  output logic [15:0]     ill_cnt,
`endif
  output logic            out_illegal
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5;
  logic [XLEN-1:0] imm_q [DEPTH];
  logic [2:0]      fmt_q [DEPTH];
  logic            ill_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     cnt_q, cnt_d;
  logic [2:0]      dec_fmt;
  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm;
  logic            dec_ill, push, pop;
  always_comb begin
    dec_fmt = F_NONE;
    case (in_inst[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: dec_fmt = F_I;
      7'b0011011: dec_fmt = (XLEN == 64) ? F_I : F_NONE;
      7'b0100011: dec_fmt = F_S;
      7'b1100011: dec_fmt = F_B;
      7'b0110111, 7'b0010111: dec_fmt = F_U;
      7'b1101111: dec_fmt = F_J;
      default: dec_fmt = F_NONE;
    endcase
    dec_ill = dec_fmt == F_NONE;
    dec_imm32 = (dec_fmt == F_I) ? {{20{in_inst[31]}}, in_inst[31:20]} :
                (dec_fmt == F_S) ? {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]} :
                (dec_fmt == F_B) ? {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0} :
                (dec_fmt == F_U) ? {in_inst[31:12], 12'b0} :
                (dec_fmt == F_J) ? {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0} :
                32'd0;
    dec_imm = XLEN'($signed(dec_imm32));
  end
  assign in_ready  = cnt_q != (AW+1)'(DEPTH);
  assign out_valid = cnt_q != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign cnt_d     = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign out_imm     = out_valid ? imm_q[rptr_q] : '0;
  assign out_fmt     = out_valid ? fmt_q[rptr_q] : '0;
  assign out_illegal = out_valid ? ill_q[rptr_q] : 1'b0;
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= push ? wptr_q + 1'b1 : wptr_q;
      rptr_q <= pop ? rptr_q + 1'b1 : rptr_q;
      cnt_q  <= cnt_d;
    end
  end
  // Storage needs no reset: outputs are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      imm_q[wptr_q] <= dec_imm;
      fmt_q[wptr_q] <= dec_fmt;
      ill_q[wptr_q] <= dec_ill;
    end
  end
`ifdef IMM_GEN_ILL_CNT_EN
  logic [15:0] ill_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n)
      ill_cnt_q <= '0;
    else if (push && !flush && dec_ill && ill_cnt_q != 16'hFFFF)
      ill_cnt_q <= ill_cnt_q + 16'd1;
  end
  assign ill_cnt = ill_cnt_q;
`endif
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: queue-based reference model, directed corner cases, then random traffic.
module tb_imm_gen_pipe;
  localparam int XLEN = 32, DEPTH = 2;
  logic clk = 0, rst_n, in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
  logic [31:0] in_inst;
  logic [XLEN-1:0] out_imm;
  logic [2:0] out_fmt;
`ifdef IMM_GEN_ILL_CNT_EN
  logic [15:0] ill_cnt;
`endif
  imm_gen_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt),
`ifdef IMM_GEN_ILL_CNT_EN
    .ill_cnt(ill_cnt),
`endif
    .out_illegal(out_illegal));
  always #5 clk = ~clk;
  typedef struct packed { logic [31:0] imm; logic [2:0] fmt; logic ill; } ent_t;
  ent_t q[$];
  int errs = 0, checks = 0;
  int ill_exp = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic ent_t model(input logic [31:0] i);
    ent_t e;
    int si;
    si = $signed(i);
    e = '0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67: begin e.fmt = 1; e.imm = si >>> 20; end
      7'h1B: if (XLEN == 64) begin e.fmt = 1; e.imm = si >>> 20; end
      7'h23: begin e.fmt = 2; e.imm = ((si >>> 25) << 5) | int'(i[11:7]); end
      7'h63: begin e.fmt = 3; e.imm = ((si >>> 31) << 12) | (int'(i[7]) << 11) | (int'(i[30:25]) << 5) | (int'(i[11:8]) << 1); end
      7'h37, 7'h17: begin e.fmt = 4; e.imm = i & 32'hFFFFF000; end
      7'h6F: begin e.fmt = 5; e.imm = ((si >>> 31) << 20) | (int'(i[19:12]) << 12) | (int'(i[20]) << 11) | (int'(i[30:21]) << 1); end
      default: e.fmt = 0;
    endcase
    e.ill = e.fmt == 0;
    return e;
  endfunction
  task automatic cycle(input logic v, input logic [31:0] inst, input logic fl, input logic ordy, input logic rn);
    logic pop, push;
    ent_t e;
    in_valid = v; in_inst = inst; flush = fl; out_ready = ordy; rst_n = rn;
    @(posedge clk);
    pop = q.size() > 0 && ordy;
    push = v && q.size() < DEPTH;
    e = model(inst);
    if (!rn) ill_exp = 0;
    else if (!fl && push && e.ill && ill_exp != 16'hFFFF) ill_exp++;
    if (!rn || fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
    @(negedge clk);
    e = (q.size() != 0) ? q[0] : '0;
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("out_imm", out_imm, e.imm);
    chk("out_fmt", out_fmt, e.fmt);
    chk("out_illegal", out_illegal, e.ill);
`ifdef IMM_GEN_ILL_CNT_EN
    chk("ill_cnt", ill_cnt, ill_exp);
`endif
  endtask
  logic [6:0] ops [10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h1B, 7'h33};
  initial begin
    logic [31:0] r;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_ready", in_ready, 1);
    cycle(1, 32'hFFC12083, 0, 1, 1);
    chk("lw_imm", out_imm, 32'hFFFFFFFC);
    chk("lw_fmt", out_fmt, 1);
    cycle(1, 32'hFE000CE3, 0, 1, 1);
    chk("beq_imm", out_imm, 32'hFFFFFFF8);
    chk("beq_fmt", out_fmt, 3);
    cycle(1, 32'h123452B7, 0, 1, 1);
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_fmt", out_fmt, 4);
    cycle(1, 32'h001000EF, 0, 1, 1);
    chk("jal_imm", out_imm, 32'h00000800);
    chk("jal_fmt", out_fmt, 5);
    cycle(0, 0, 0, 1, 1);
    chk("drained", out_valid, 0);
    cycle(1, 32'h00000033, 0, 0, 1);
    chk("r_ill", out_illegal, 1);
    chk("r_imm", out_imm, 0);
    chk("r_fmt", out_fmt, 0);
    cycle(0, 0, 1, 0, 1);
`ifdef IMM_GEN_ILL_CNT_EN
    chk("ill_cnt_after_flush", ill_cnt, 1);
`endif
    cycle(1, 32'hFFC12083, 0, 0, 1);
    cycle(1, 32'hFE000CE3, 0, 0, 1);
    chk("full_ready", in_ready, 0);
    cycle(1, 32'h123452B7, 0, 0, 1);
    chk("held_head", out_imm, 32'hFFFFFFFC);
    cycle(1, 32'h123452B7, 0, 1, 1);
    chk("order_2nd", out_imm, 32'hFFFFFFF8);
    cycle(1, 32'h123452B7, 0, 1, 1);
    chk("order_3rd", out_imm, 32'h12345000);
    cycle(1, 32'h001000EF, 0, 0, 1);
    chk("refull_ready", in_ready, 0);
    cycle(1, 32'hFFC12083, 1, 1, 1);
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    cycle(1, 32'hFFC12083, 0, 0, 1);
    cycle(1, 32'hFE000CE3, 1, 1, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_imm", out_imm, 0);
    cycle(1, 32'h001000EF, 0, 0, 1);
    chk("post_rst_imm", out_imm, 32'h00000800);
    for (int k = 0; k < 3000; k++) begin
      r = $urandom();
      r[6:0] = ops[$urandom_range(0, 9)];
      cycle($urandom_range(0, 3) != 0, r, $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 99) != 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH, default 2, output queue entries; power of two, >=2.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, in_inst is valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept; equals !full, registered-state only.
REQ-007 SHALL have port in_inst, input, 32, raw RV instruction word.
REQ-008 SHALL have port flush, input, 1, synchronous queue discard.
REQ-009 SHALL have port out_valid, output, 1, queue head valid; equals !empty.
REQ-010 SHALL have port out_ready, input, 1, consumer takes head.
REQ-011 SHALL have port out_imm, output, XLEN, sign-extended immediate of head.
REQ-012 SHALL have port out_fmt, output, 3, head format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
REQ-013 SHALL have port out_illegal, output, 1, head opcode unrecognised.

Function
REQ-014 SHALL decode opcode in_inst[6:0]: 0000011, 0010011, 1100111 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; 0011011 -> I only when XLEN=64.
REQ-015 SHALL form I = inst[31:20]; S = {inst[31:25],inst[11:7]}; B = {inst[31],inst[7],inst[30:25],inst[11:8],0}; U = {inst[31:12],12'b0}; J = {inst[31],inst[19:12],inst[20],inst[30:21],0}; all sign-extended from inst[31] to XLEN.
REQ-016 SHALL, for any other opcode, produce imm=0, fmt=NONE, illegal=1; illegal=0 otherwise.
REQ-017 SHALL push the decoded {imm,fmt,illegal} into the queue when in_valid && in_ready.
REQ-018 SHALL pop the head when out_valid && out_ready.
REQ-019 SHALL give latency one cycle: entry accepted on edge N into empty queue drives out_valid high after edge N.
REQ-020 SHALL preserve FIFO order; pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
REQ-021 SHALL allow simultaneous push and pop when neither full nor empty, occupancy unchanged.
REQ-022 SHALL, when full, hold in_ready low for that cycle even if out_ready is high (no combinational ready path).
REQ-023 SHALL ignore pop when empty; out_imm/out_fmt/out_illegal are 0 when out_valid=0.
REQ-024 SHALL, on flush, empty the queue next edge; flush overrides push and pop in the same cycle.

Reset
REQ-025 SHALL, when rst_n=0 at an edge, clear pointers and occupancy: out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_illegal=0.
REQ-026 SHALL discard all queued entries if reset asserts mid-operation; reset overrides flush, push and pop.

Configuration
REQ-027 SHALL, with macro IMM_GEN_ILL_CNT_EN defined, add output ill_cnt (16 bits) counting accepted illegal instructions, saturating at 0xFFFF, cleared by reset only (not flush).
REQ-028 SHALL, without IMM_GEN_ILL_CNT_EN, omit ill_cnt port and counter logic; all other behaviour identical.

Verification
REQ-029 SHALL cover: push 0xFFC12083 (lw), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFC, out_fmt=1, out_illegal=0.
REQ-030 SHALL cover: push 0xFE000CE3 (beq -8) -> out_imm=0xFFFFFFF8, fmt=3; push 0x123452B7 (lui) -> 0x12345000, fmt=4; push 0x001000EF (jal) -> 0x00000800, fmt=5.
REQ-031 SHALL cover: DEPTH=2, out_ready=0, push three words -> in_ready low after second accept, third held; release out_ready -> outputs in push order, third accepted one cycle later.
REQ-032 SHALL cover: push 0x00000033 (R-type) -> out_illegal=1, out_imm=0, fmt=0; with IMM_GEN_ILL_CNT_EN ill_cnt increments 0->1 and survives a following flush.
REQ-033 SHALL cover: queue full, assert flush with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, nothing pushed.
REQ-034 SHALL cover: queue holding one entry, rst_n=0 for one edge -> out_valid=0 and all outputs 0 after that edge; normal push works the cycle after release.
